// File: rtl/multiword_add_sequencer.sv
// Multi-precision add/subtract sequencer. Streams operand words LSW first
// through a 4-bit-group carry-lookahead adder, chaining the carry between words.
module multiword_add_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_sub,
    input  logic [CNT_W-1:0] i_num_words,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_last,
    output logic             o_carry_out,
    output logic             o_overflow,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned NGRP = WIDTH / 4;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e           r_state;
    logic             r_sub;
    logic [CNT_W-1:0] r_num_words;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_last;
    logic             r_carry_out;
    logic             r_overflow;
    logic             r_done;

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;
    logic             w_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_is_last;

    assign w_b_eff    = r_sub ? ~i_b : i_b;
    assign w_in_ready = (r_state == StRun) && (!r_out_valid || i_out_ready);
    assign w_in_fire  = i_in_valid && w_in_ready;
    assign w_out_fire = r_out_valid && i_out_ready;
    assign w_is_last  = (r_cnt == (r_num_words - CNT_W'(1)));
    assign w_ovf      = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);

    // Carry-lookahead adder: group G/P per nibble, group carries resolved by lookahead
    always_comb begin
        logic [WIDTH-1:0] v_g;
        logic [WIDTH-1:0] v_p;
        logic [WIDTH-1:0] v_c;
        logic [NGRP-1:0]  v_gg;
        logic [NGRP-1:0]  v_gp;
        logic [NGRP:0]    v_gc;
        logic             v_pp;
        logic             v_acc;
        v_g  = i_a & w_b_eff;
        v_p  = i_a ^ w_b_eff;
        v_c  = '0;
        v_gg = '0;
        v_gp = '0;
        v_gc = '0;
        for (int k = 0; k < int'(NGRP); k++) begin
            v_gg[k] = v_g[4*k+3]
                    | (v_p[4*k+3] & v_g[4*k+2])
                    | (v_p[4*k+3] & v_p[4*k+2] & v_g[4*k+1])
                    | (v_p[4*k+3] & v_p[4*k+2] & v_p[4*k+1] & v_g[4*k]);
            v_gp[k] = &v_p[4*k +: 4];
        end
        v_gc[0] = r_carry;
        for (int k = 0; k < int'(NGRP); k++) begin
            v_pp  = 1'b1;
            v_acc = 1'b0;
            for (int j = k; j >= 0; j--) begin
                v_acc = v_acc | (v_pp & v_gg[j]);
                v_pp  = v_pp & v_gp[j];
            end
            v_gc[k+1] = v_acc | (v_pp & r_carry);
        end
        for (int k = 0; k < int'(NGRP); k++) begin
            v_c[4*k] = v_gc[k];
            for (int i = 0; i < 3; i++) begin
                v_c[4*k+i+1] = v_g[4*k+i] | (v_p[4*k+i] & v_c[4*k+i]);
            end
        end
        w_sum  = v_p ^ v_c;
        w_cout = v_gc[NGRP];
    end

    // Control FSM, carry chain, word counter and registered result stage
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_sub       <= 1'b0;
            r_num_words <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_last      <= 1'b0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_start && (i_num_words != '0)) begin
                        r_sub       <= i_sub;
                        r_num_words <= i_num_words;
                        r_cnt       <= '0;
                        r_carry     <= i_sub;
                        r_state     <= StRun;
                    end
                end
                StRun: begin
                    if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                    end
                    // A load in the same cycle as a handshake keeps out_valid high
                    if (w_in_fire) begin
                        r_out_valid <= 1'b1;
                        r_sum       <= w_sum;
                        r_last      <= w_is_last;
                        r_carry_out <= w_is_last & w_cout;
                        r_overflow  <= w_is_last & w_ovf;
                        r_carry     <= w_cout;
                        r_cnt       <= r_cnt + CNT_W'(1);
                        if (w_is_last) begin
                            r_state <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (w_out_fire && r_last) begin
                        r_out_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_sum       = r_sum;
    assign o_last      = r_last;
    assign o_carry_out = r_carry_out;
    assign o_overflow  = r_overflow;
    assign o_busy      = (r_state != StIdle);
    assign o_done      = r_done;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench: directed vector table, hand sequences for reset and
// backpressure, plus randomized operations checked against a big-integer model.
module tb_multiword_add_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic        i_sub;
    logic [3:0]  i_num_words;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [15:0] i_a;
    logic [15:0] i_b;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [15:0] o_sum;
    logic        o_last;
    logic        o_carry_out;
    logic        o_overflow;
    logic        o_busy;
    logic        o_done;

    multiword_add_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_sub       (i_sub),
        .i_num_words (i_num_words),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_a         (i_a),
        .i_b         (i_b),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_sum       (o_sum),
        .o_last      (o_last),
        .o_carry_out (o_carry_out),
        .o_overflow  (o_overflow),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic            sub;
        logic [3:0]      n;
        logic [3:0][15:0] a;
        logic [3:0][15:0] b;
        logic [3:0][15:0] s;
        logic            cout;
        logic            ov;
    } vec_t;

    vec_t tbl [6];

    int n_vec = 0;
    int n_err = 0;

    // Current operation and its expected results
    logic        op_sub;
    int          op_n;
    logic [15:0] op_a [16];
    logic [15:0] op_b [16];
    logic [15:0] e_sum [16];
    logic        e_cout;
    logic        e_ov;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole operation as one big integer: A + (sub ? ~B : B) + sub
    task automatic model();
        logic [256:0] ta;
        logic [256:0] tb;
        logic [256:0] tt;
        logic [15:0]  a_t;
        logic [15:0]  bp_t;
        ta = '0;
        tb = '0;
        for (int i = 0; i < op_n; i++) begin
            ta[16*i +: 16] = op_a[i];
            tb[16*i +: 16] = op_sub ? ~op_b[i] : op_b[i];
        end
        tt = ta + tb + {256'd0, op_sub};
        for (int i = 0; i < op_n; i++) e_sum[i] = tt[16*i +: 16];
        e_cout = tt[16*op_n];
        a_t    = op_a[op_n-1];
        bp_t   = tb[16*(op_n-1) +: 16];
        e_ov   = (a_t[15] == bp_t[15]) && (e_sum[op_n-1][15] != a_t[15]);
    endtask

    // mode 0: full rate, 1: random valid/ready plus stray starts, 2: 3-cycle stall after first result
    task automatic run_op(input int mode);
        int          in_idx;
        int          out_idx;
        int          cyc;
        int          stall_left;
        logic        held;
        logic [15:0] h_sum;
        logic        h_last;
        cyc = 0;
        while (o_busy && cyc < 200) begin
            @(negedge i_clk);
            cyc++;
        end
        if (o_busy) begin
            chk("idle_timeout", 32'(o_busy), 32'd0);
            return;
        end
        i_start     = 1'b1;
        i_sub       = op_sub;
        i_num_words = 4'(op_n);
        i_in_valid  = 1'b0;
        i_out_ready = 1'b1;
        #1;
        chk("in_ready_start_cycle", 32'(o_in_ready), 32'd0);
        @(negedge i_clk);
        i_start = 1'b0;
        chk("busy_after_start", 32'(o_busy), 32'd1);
        in_idx     = 0;
        out_idx    = 0;
        stall_left = 3;
        held       = 1'b0;
        h_sum      = '0;
        h_last     = 1'b0;
        cyc        = 0;
        while (out_idx < op_n && cyc < 2000) begin
            if (held) begin
                chk("hold_valid", 32'(o_out_valid), 32'd1);
                chk("hold_sum", 32'(o_sum), 32'(h_sum));
                chk("hold_last", 32'(o_last), 32'(h_last));
            end
            if (mode != 1 && cyc == 0) chk("in_ready_first", 32'(o_in_ready), 32'd1);
            if (mode != 1 && cyc == 1) chk("latency_valid", 32'(o_out_valid), 32'd1);
            i_in_valid  = (in_idx < op_n) && (mode != 1 || $urandom_range(3) != 0);
            i_a         = (in_idx < op_n) ? op_a[in_idx] : 16'($urandom);
            i_b         = (in_idx < op_n) ? op_b[in_idx] : 16'($urandom);
            i_out_ready = 1'b1;
            if (mode == 1) i_out_ready = ($urandom_range(2) != 0);
            if (mode == 2 && o_out_valid && stall_left > 0) begin
                i_out_ready = 1'b0;
                stall_left--;
            end
            i_start     = (mode == 1) && ($urandom_range(3) == 0);
            i_num_words = 4'($urandom);
            i_sub       = 1'($urandom);
            #1;
            if (o_out_valid && !i_out_ready) begin
                chk("in_ready_stall", 32'(o_in_ready), 32'd0);
                held   = 1'b1;
                h_sum  = o_sum;
                h_last = o_last;
            end else begin
                held = 1'b0;
            end
            if (i_in_valid && o_in_ready) in_idx++;
            if (o_out_valid && i_out_ready) begin
                chk("sum", 32'(o_sum), 32'(e_sum[out_idx]));
                chk("last", 32'(o_last), 32'(out_idx == op_n - 1));
                chk("carry_out", 32'(o_carry_out), (out_idx == op_n - 1) ? 32'(e_cout) : 32'd0);
                chk("overflow", 32'(o_overflow), (out_idx == op_n - 1) ? 32'(e_ov) : 32'd0);
                out_idx++;
            end
            @(negedge i_clk);
            cyc++;
        end
        i_start    = 1'b0;
        i_in_valid = 1'b0;
        if (out_idx < op_n) begin
            chk("op_timeout", 32'(out_idx), 32'(op_n));
        end else begin
            chk("done_pulse", 32'(o_done), 32'd1);
            chk("busy_in_done", 32'(o_busy), 32'd0);
            @(negedge i_clk);
            chk("done_one_cycle", 32'(o_done), 32'd0);
        end
    endtask

    task automatic load_vec(input int k);
        op_sub = tbl[k].sub;
        op_n   = int'(tbl[k].n);
        for (int j = 0; j < 4; j++) begin
            op_a[j]  = tbl[k].a[j];
            op_b[j]  = tbl[k].b[j];
            e_sum[j] = tbl[k].s[j];
        end
        e_cout = tbl[k].cout;
        e_ov   = tbl[k].ov;
    endtask

    initial begin
        tbl[0] = '{sub: 1'b0, n: 4'd2, a: 64'h0000_0000_0001_FFFF, b: 64'h0000_0000_0000_0001,
                   s: 64'h0000_0000_0002_0000, cout: 1'b0, ov: 1'b0};
        tbl[1] = '{sub: 1'b1, n: 4'd1, a: 64'h5, b: 64'h7, s: 64'hFFFE, cout: 1'b0, ov: 1'b0};
        tbl[2] = '{sub: 1'b1, n: 4'd1, a: 64'h7, b: 64'h5, s: 64'h0002, cout: 1'b1, ov: 1'b0};
        tbl[3] = '{sub: 1'b0, n: 4'd1, a: 64'h7FFF, b: 64'h1, s: 64'h8000, cout: 1'b0, ov: 1'b1};
        tbl[4] = '{sub: 1'b0, n: 4'd1, a: 64'hFFFF, b: 64'h1, s: 64'h0000, cout: 1'b1, ov: 1'b0};
        tbl[5] = '{sub: 1'b0, n: 4'd1, a: 64'h1234, b: 64'h1, s: 64'h1235, cout: 1'b0, ov: 1'b0};

        i_rst       = 1'b1;
        i_start     = 1'b0;
        i_sub       = 1'b0;
        i_num_words = '0;
        i_in_valid  = 1'b0;
        i_a         = '0;
        i_b         = '0;
        i_out_ready = 1'b1;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_out_valid", 32'(o_out_valid), 32'd0);
        chk("rst_in_ready", 32'(o_in_ready), 32'd0);
        chk("rst_sum", 32'(o_sum), 32'd0);
        chk("rst_last", 32'(o_last), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);

        // Directed table
        for (int k = 0; k < 5; k++) begin
            load_vec(k);
            run_op(0);
        end

        // Zero-length start is ignored
        i_start     = 1'b1;
        i_num_words = 4'd0;
        @(negedge i_clk);
        i_start = 1'b0;
        chk("zero_len_busy", 32'(o_busy), 32'd0);
        chk("zero_len_in_ready", 32'(o_in_ready), 32'd0);

        // Backpressure: 4 words, sink stalls 3 cycles after first result
        op_sub = 1'b0;
        op_n   = 4;
        for (int j = 0; j < 4; j++) begin
            op_a[j] = 16'($urandom);
            op_b[j] = 16'($urandom);
        end
        model();
        run_op(2);

        // Reset after one of three words is accepted
        i_start     = 1'b1;
        i_sub       = 1'b0;
        i_num_words = 4'd3;
        @(negedge i_clk);
        i_start    = 1'b0;
        i_in_valid = 1'b1;
        i_a        = 16'hAAAA;
        i_b        = 16'hFFFF;
        #1;
        chk("abort_in_ready", 32'(o_in_ready), 32'd1);
        @(negedge i_clk);
        i_in_valid = 1'b0;
        i_rst      = 1'b1;
        #1;
        chk("abort_out_valid", 32'(o_out_valid), 32'd0);
        chk("abort_sum", 32'(o_sum), 32'd0);
        chk("abort_carry_out", 32'(o_carry_out), 32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("abort_no_done", 32'(o_done), 32'd0);
        chk("abort_in_ready_low", 32'(o_in_ready), 32'd0);
        load_vec(5);
        run_op(0);

        // Randomized operations
        for (int t = 0; t < 50; t++) begin
            op_sub = 1'($urandom);
            op_n   = $urandom_range(15, 1);
            for (int j = 0; j < op_n; j++) begin
                op_a[j] = ($urandom_range(4) == 0) ? 16'hFFFF : 16'($urandom);
                op_b[j] = ($urandom_range(4) == 0) ? 16'h0000 : 16'($urandom);
            end
            model();
            run_op((t % 5 == 0) ? 0 : 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multiword_add_sequencer.md
# multiword_add_sequencer

Sequencer that drives the team's 4-bit-group carry-lookahead adder datapath to perform multi-precision add or subtract on operands streamed one word per beat, least-significant word first. It holds the inter-word carry in a register, counts words, and applies valid/ready flow control on both sides. It sits between an operand source (e.g. a register-file reader or DMA) and a result sink. It is the only block that sequences the adder.

## Interface
Parameters:
- WIDTH, 16, word width in bits. Must be a multiple of 4, one lookahead group per 4 bits.
- CNT_W, 4, width of the word-count field. Maximum operation length is 2^CNT_W - 1 words.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  begin an operation. Sampled only in IDLE.
- sub  input  1  0 = A+B, 1 = A-B. Latched at start.
- num_words  input  CNT_W  operation length in words. Latched at start.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  operand beat accepted when in_valid && in_ready.
- a, b  input  WIDTH  operand words.
- out_valid  output  1  result beat valid.
- out_ready  input  1  sink accepts the result beat.
- sum  output  WIDTH  result word.
- last  output  1  qualifies the final result beat.
- carry_out  output  1  final carry. For subtraction, 0 means borrow. Valid with last.
- overflow  output  1  two's-complement overflow of the full-width result. Valid with last.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the operation completes.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE → RUN when start=1 and num_words≠0. On this transition:
  - latch sub and num_words;
  - clear word counter to 0;
  - carry register ← sub.
- start with num_words=0 is ignored and the block stays in IDLE. start outside IDLE is ignored.
- RUN datapath, per accepted beat:
  - B' = sub ? ~b : b;
  - result = a + B' + carry, computed as WIDTH/4 groups with per-group generate/propagate resolved by lookahead;
  - carry register ← carry out of bit WIDTH-1;
  - counter increments.
- in_ready = (state==RUN) && (!out_valid || out_ready). This is a single output register with no skid buffer.
- Accepted beat loads the output register: sum, last = (counter == num_words-1), carry_out, and overflow = (a[W-1]==B'[W-1]) && (sum[W-1]!=a[W-1]).
- carry_out and overflow are 0 on non-last beats.
- After the last beat is accepted, RUN → DRAIN.
- DRAIN → IDLE when out_valid && out_ready with last=1. done pulses high in the IDLE cycle that follows that handshake.
- out_valid clears on handshake unless a new beat loads in the same cycle, in which case it stays high with the new data.
- Arithmetic wraps modulo 2^WIDTH per word. No saturation.

## Timing
- Reset values:
  - state=IDLE, out_valid=0, in_ready=0;
  - sum=0, last=0, carry_out=0, overflow=0;
  - busy=0, done=0;
  - carry register=0, counter=0.
- Reset asserted mid-operation aborts immediately. No done pulse; partial results are discarded.
- Latency: accepted input beat → out_valid high on the next rising edge. Single-word add: start at cycle 0, beat accepted at cycle 1, out_valid at cycle 2.
- Throughput is one word per cycle while out_ready=1.
- in_ready is low in the IDLE→RUN transition cycle, i.e. the cycle start is sampled.
- out_valid, sum, last, carry_out and overflow are held stable while out_valid && !out_ready.
- in_ready is low throughout DRAIN.
- done is high for exactly one cycle per completed operation. busy is low in the done cycle, so a new start is accepted in that same cycle.

## Test plan
- Add, num_words=2, A={0x0001,0xFFFF}, B={0x0000,0x0001} (words listed LSW last). Expect sum beats 0x0000 then 0x0002, last on beat 2, carry_out=0, overflow=0, done one cycle after the 2nd handshake.
- Subtract, num_words=1, A=0x0005, B=0x0007. Expect sum=0xFFFE, carry_out=0 (borrow), overflow=0. Then A=0x0007, B=0x0005: expect sum=0x0002, carry_out=1.
- Overflow/carry, num_words=1:
  - add 0x7FFF+0x0001 → sum=0x8000, overflow=1, carry_out=0;
  - add 0xFFFF+0x0001 → sum=0x0000, carry_out=1, overflow=0.
- Backpressure, num_words=4, in_valid held high, out_ready low for 3 cycles after the first result. Expect in_ready=0 during the stall, first result held unchanged, all 4 results correct and in order, no beat lost or duplicated.
- start with num_words=0 → busy stays 0 and in_ready stays 0. start pulsed while busy → ignored, and the current operation completes normally.
- Reset asserted after 1 of 3 words is accepted. Expect all outputs at reset values on the next cycle, no done pulse. A following 1-word add 0x1234+0x0001 yields 0x1235 with carry in 0.
